// File: rtl/ws2812_framebuffer_if.sv
// rtl/ws2812_framebuffer_if.sv - host and scan-driver ports of the WS2812 frame buffer
// Host pixel access, clear control and LED-chain scan read.
interface ws2812_framebuffer_if #(
  parameter int BPC = 8
);
  logic [7:0]       row;
  logic [7:0]       column;
  logic             wr_en;
  logic [3*BPC-1:0] wr_data;
  logic             rd_en;
  logic [3*BPC-1:0] rd_data;
  logic             rd_valid;
  logic             clear;
  logic             busy;
  logic             scan_en;
  logic [15:0]      scan_idx;
  logic [3*BPC-1:0] scan_data;
  logic             scan_valid;

  modport master (
    output row, column, wr_en, wr_data, rd_en, clear, scan_en, scan_idx,
    input  rd_data, rd_valid, busy, scan_data, scan_valid
  );

  modport slave (
    input  row, column, wr_en, wr_data, rd_en, clear, scan_en, scan_idx,
    output rd_data, rd_valid, busy, scan_data, scan_valid
  );
endinterface

// File: rtl/ws2812_framebuffer.sv
// rtl/ws2812_framebuffer.sv - WS2812 LED matrix frame buffer with clear sweep
// Host read/write port, independent scan read port in chain order, and a one-pixel-per-cycle clear FSM.
module ws2812_framebuffer #(
  parameter int               WIDTH       = 32,
  parameter int               HEIGHT      = 16,
  parameter int               BPC         = 8,
  parameter int               SERPENTINE  = 0,
  parameter logic [3*BPC-1:0] CLEAR_VALUE = {{BPC{1'b1}}, {(2*BPC){1'b0}}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ws2812_framebuffer_if.slave    bus
);

  localparam int          PW    = 3 * BPC;
  localparam int          DEPTH = WIDTH * HEIGHT;
  localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] W32   = WIDTH;
  localparam logic [31:0] H32   = HEIGHT;
  localparam logic [31:0] D32   = DEPTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          sweep_we;

  logic [PW-1:0] mem [DEPTH];

  logic          host_in_range;
  logic [AW-1:0] host_addr;
  logic          host_we;

  logic [31:0]   scan_row;
  logic [31:0]   scan_col;
  logic [31:0]   scan_col_m;
  logic          scan_in_range;
  logic [AW-1:0] scan_addr;

  logic [PW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic [PW-1:0] scan_data_q;
  logic          scan_valid_q;

  // Reset lands in SWEEP so the memory is filled with CLEAR_VALUE after every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        sweep_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign host_in_range = (32'(bus.row) < H32) && (32'(bus.column) < W32);
  assign host_addr     = AW'(32'(bus.row) * W32 + 32'(bus.column));
  assign host_we       = bus.wr_en && (state_q == IDLE) && !bus.clear && host_in_range;

  // Chain order to row-major address; serpentine wiring reverses odd rows.
  assign scan_row      = 32'(bus.scan_idx) / W32;
  assign scan_col      = 32'(bus.scan_idx) % W32;
  assign scan_col_m    = ((SERPENTINE != 0) && scan_row[0]) ? (W32 - 32'd1 - scan_col) : scan_col;
  assign scan_addr     = AW'(scan_row * W32 + scan_col_m);
  assign scan_in_range = 32'(bus.scan_idx) < D32;

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt_q] <= CLEAR_VALUE;
    end else if (host_we) begin
      mem[host_addr] <= bus.wr_data;
    end
  end

  // Registered reads sample the array before this edge's write: read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      scan_data_q  <= '0;
      scan_valid_q <= 1'b0;
    end else begin
      rd_valid_q   <= bus.rd_en;
      scan_valid_q <= bus.scan_en;
      if (bus.rd_en) begin
        rd_data_q <= host_in_range ? mem[host_addr] : '0;
      end
      if (bus.scan_en) begin
        scan_data_q <= scan_in_range ? mem[scan_addr] : '0;
      end
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.scan_data  = scan_data_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.busy       = (state_q == SWEEP);

endmodule

// File: doc/ws2812_framebuffer.md
WS2812_FRAMEBUFFER -- requirements
Module: ws2812_framebuffer

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  WIDTH  32  matrix columns, 1..256
  HEIGHT  16  matrix rows, 1..256
  BPC  8  bits per colour channel
  SERPENTINE  0  1 = odd rows reversed in scan order
  CLEAR_VALUE  {BPC{1}},{BPC{0}},{BPC{0}}  pixel written by clear, packed R,G,B (default red)
REQ-002 SHALL have ports (name  direction  width  meaning), one per line:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous reset, active low
  row  in  8  host pixel row
  column  in  8  host pixel column
  wr_en  in  1  write row/column with wr_data
  wr_data  in  3*BPC  packed {R,G,B}
  rd_en  in  1  read row/column
  rd_data  out  3*BPC  host read data
  rd_valid  out  1  rd_data valid, one-cycle pulse
  clear  in  1  start clear sweep, level sampled
  busy  out  1  clear sweep in progress
  scan_en  in  1  driver read request
  scan_idx  in  16  pixel position in LED chain order
  scan_data  out  3*BPC  driver read data
  scan_valid  out  1  scan_data valid, one-cycle pulse
REQ-003 SHALL use one clock and an asynchronous, active-low reset named rst_n; clock named clk.

Function
REQ-004 SHALL store WIDTH*HEIGHT pixels of 3*BPC bits; address = row*WIDTH + column.
REQ-005 SHALL commit a write on the rising edge where wr_en=1, busy=0, clear=0, row<HEIGHT and column<WIDTH; all other writes are dropped silently.
REQ-006 Host read SHALL have 1-cycle latency: rd_en at edge N -> rd_data and rd_valid=1 after edge N+1, rd_valid low otherwise.
REQ-007 Out-of-range host read (row>=HEIGHT or column>=WIDTH) SHALL return rd_data=0 with rd_valid=1.
REQ-008 Read and write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-009 Scan read SHALL have 1-cycle latency, same valid-pulse rules as REQ-006, independent of and concurrent with host port.
REQ-010 Scan mapping: r = scan_idx / WIDTH, c = scan_idx % WIDTH; if SERPENTINE=1 and r odd, c = WIDTH-1-c.
REQ-011 scan_idx >= WIDTH*HEIGHT SHALL return scan_data=0 with scan_valid=1.
REQ-012 Clear FSM states IDLE and SWEEP; IDLE->SWEEP when clear=1; SWEEP writes CLEAR_VALUE to address k on the k-th cycle, k=0..WIDTH*HEIGHT-1, one pixel per cycle.
REQ-013 SWEEP->IDLE after writing address WIDTH*HEIGHT-1; busy=1 exactly while in SWEEP (WIDTH*HEIGHT cycles).
REQ-014 clear asserted while busy=1 SHALL be ignored (no restart); clear held high after completion SHALL start a new sweep.
REQ-015 clear and wr_en in the same idle cycle: clear wins, write dropped.
REQ-016 Reads (both ports) during SWEEP SHALL be served, returning current contents (partially cleared).

Reset
REQ-017 While rst_n=0: rd_data=0, rd_valid=0, scan_data=0, scan_valid=0, sweep counter=0, FSM in SWEEP, busy=1.
REQ-018 After rst_n release SHALL perform a full sweep (REQ-012) so memory equals CLEAR_VALUE before busy first falls; memory itself needs no reset.
REQ-019 rst_n assertion mid-sweep SHALL restart the sweep from address 0 on release.

Verification
REQ-020 Reset release, defaults -> busy=1 for exactly 512 cycles; then scan_idx 0..511 all return 24'hFF0000.
REQ-021 Write (row 3, column 5, 24'h00FF00) idle, then rd_en same coords -> next cycle rd_valid=1, rd_data=24'h00FF00; address 101.
REQ-022 SERPENTINE=1: write (row 1, column 31, 24'h0000AA) -> scan_idx 32 returns 24'h0000AA; scan_idx 63 returns 24'hFF0000.
REQ-023 wr_en during busy, and wr_en at row 16 -> memory unchanged, reads return 24'hFF0000.
REQ-024 clear pulsed at sweep cycle 100 -> busy still falls at cycle 512; clear+wr_en same idle cycle -> write lost after sweep.
REQ-025 rd_en and scan_en same cycle, different addresses, plus out-of-range scan_idx 600 -> both valid next cycle, scan_data=0.
